// File: rtl/iq_entry_allocator_pkg.sv
// Shared scheduler types for the issue-queue entry allocator.
// Default geometry plus the index/count/one-hot paths and the allocator state enum.
package iq_entry_allocator_pkg;

    localparam int unsigned IQ_ENTRY_NUM      = 16;
    localparam int unsigned IQ_DISPATCH_WIDTH = 2;
    localparam int unsigned IQ_ISSUE_WIDTH    = 2;
    localparam int unsigned IQ_IDX_W          = $clog2(IQ_ENTRY_NUM);
    localparam int unsigned IQ_CNT_W          = $clog2(IQ_ENTRY_NUM) + 1;

    typedef logic [IQ_IDX_W-1:0]     IssueQueueIndexPath;
    typedef logic [IQ_CNT_W-1:0]     IssueQueueCountPath;
    typedef logic [IQ_ENTRY_NUM-1:0] IssueQueueOneHotPath;

    typedef enum logic {
        IQA_NORMAL  = 1'b0,
        IQA_RECOVER = 1'b1
    } IQ_AllocStatePath;

endpackage

// File: rtl/iq_entry_allocator_if.sv
// Dispatch/issue/recovery bundle between the scheduler front end and the IQ entry allocator.
// master = scheduler side, slave = allocator side.
interface iq_entry_allocator_if
    import iq_entry_allocator_pkg::*;
#(
    parameter int unsigned ENTRY_NUM      = IQ_ENTRY_NUM,
    parameter int unsigned DISPATCH_WIDTH = IQ_DISPATCH_WIDTH,
    parameter int unsigned ISSUE_WIDTH    = IQ_ISSUE_WIDTH
);
    localparam int unsigned IDX_W = $clog2(ENTRY_NUM);
    localparam int unsigned CNT_W = $clog2(ENTRY_NUM) + 1;

    logic [DISPATCH_WIDTH-1:0]            allocReq;
    logic                                 allocOK;
    logic [DISPATCH_WIDTH-1:0][IDX_W-1:0] allocPtr;
    logic [ISSUE_WIDTH-1:0]               releaseValid;
    logic [ISSUE_WIDTH-1:0][IDX_W-1:0]    releasePtr;
    logic                                 flushValid;
    logic [ENTRY_NUM-1:0]                 flushVector;
    logic                                 recovering;
    logic [CNT_W-1:0]                     freeCount;

    modport master (
        output allocReq, releaseValid, releasePtr, flushValid, flushVector,
        input  allocOK, allocPtr, recovering, freeCount
    );

    modport slave (
        input  allocReq, releaseValid, releasePtr, flushValid, flushVector,
        output allocOK, allocPtr, recovering, freeCount
    );

endinterface

// File: rtl/iq_entry_allocator_free_list_fifo.sv
// Circular free list of IQ entry indices: multi-pop from head, ordered multi-push at tail.
// Full and empty share head==tail; only the counter tells them apart.
module iq_free_list_fifo #(
    parameter int unsigned ENTRY_NUM = 16,
    parameter int unsigned POP_N     = 2,
    parameter int unsigned PUSH_N    = 3,
    localparam int unsigned IDX_W    = $clog2(ENTRY_NUM),
    localparam int unsigned CNT_W    = $clog2(ENTRY_NUM) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CNT_W-1:0]             pop_cnt_i,
    input  logic [PUSH_N-1:0]            push_valid_i,
    input  logic [PUSH_N-1:0][IDX_W-1:0] push_data_i,
    output logic [POP_N-1:0][IDX_W-1:0]  peek_c_o,
    output logic [CNT_W-1:0]             count_o
);

    logic [IDX_W-1:0] list_q [ENTRY_NUM];
    logic [IDX_W-1:0] list_d [ENTRY_NUM];
    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] push_cnt;

    // Valid pushes land at consecutive tail slots in port order.
    always_comb begin
        list_d   = list_q;
        tail_d   = tail_q;
        push_cnt = '0;
        for (int p = 0; p < int'(PUSH_N); p++) begin
            if (push_valid_i[p]) begin
                list_d[tail_d] = push_data_i[p];
                tail_d         = tail_d + IDX_W'(1);
                push_cnt       = push_cnt + CNT_W'(1);
            end
        end
        head_d  = head_q + pop_cnt_i[IDX_W-1:0];
        count_d = count_q - pop_cnt_i + push_cnt;
    end

    always_comb begin
        for (int j = 0; j < int'(POP_N); j++) begin
            peek_c_o[j] = list_q[head_q + IDX_W'(j)];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRY_NUM); i++) begin
                list_q[i] <= IDX_W'(i);
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CNT_W'(ENTRY_NUM);
        end else begin
            assert (count_d <= CNT_W'(ENTRY_NUM))
                else $error("free list overflow: count %0d", count_d);
            list_q  <= list_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/iq_entry_allocator.sv
// IQ entry allocator: compacted zero-latency grants from the free list, issue reclaim,
// and a NORMAL/RECOVER FSM that drains flushed entries back one per cycle.
module iq_entry_allocator
    import iq_entry_allocator_pkg::*;
#(
    parameter int unsigned ENTRY_NUM      = IQ_ENTRY_NUM,
    parameter int unsigned DISPATCH_WIDTH = IQ_DISPATCH_WIDTH,
    parameter int unsigned ISSUE_WIDTH    = IQ_ISSUE_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    iq_entry_allocator_if.slave  bus
);

    localparam int unsigned IDX_W  = $clog2(ENTRY_NUM);
    localparam int unsigned CNT_W  = $clog2(ENTRY_NUM) + 1;
    localparam int unsigned PUSH_N = ISSUE_WIDTH + 1;

    IQ_AllocStatePath                     state_q, state_d;
    logic [ENTRY_NUM-1:0]                 pending_q, pending_d;
    logic [ENTRY_NUM-1:0]                 rel_mask, flush_masked, drain_onehot;
    logic [IDX_W-1:0]                     drain_idx;
    logic                                 drain_valid, alloc_ok, recover_c;
    logic [CNT_W-1:0]                     req_cnt, pop_cnt, free_cnt;
    logic [DISPATCH_WIDTH-1:0][IDX_W-1:0] head_entry;
    logic [DISPATCH_WIDTH-1:0][IDX_W-1:0] alloc_ptr;
    logic [PUSH_N-1:0]                    push_valid;
    logic [PUSH_N-1:0][IDX_W-1:0]         push_data;

    // Request count and the set of entries issued this cycle.
    always_comb begin
        req_cnt  = '0;
        rel_mask = '0;
        for (int j = 0; j < int'(DISPATCH_WIDTH); j++) begin
            if (bus.allocReq[j]) req_cnt = req_cnt + CNT_W'(1);
        end
        for (int i = 0; i < int'(ISSUE_WIDTH); i++) begin
            if (bus.releaseValid[i]) rel_mask[bus.releasePtr[i]] = 1'b1;
        end
    end

    // An entry issued in the flush cycle is already reclaimed; flushing it too would free it twice.
    assign flush_masked = bus.flushVector & ~rel_mask;

    always_comb begin
        drain_idx    = '0;
        drain_onehot = '0;
        for (int e = int'(ENTRY_NUM) - 1; e >= 0; e--) begin
            if (pending_q[e]) drain_idx = IDX_W'(e);
        end
        drain_onehot[drain_idx] = |pending_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IQA_NORMAL;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        case (state_q)
            IQA_RECOVER: begin
                pending_d = (pending_q & ~drain_onehot)
                          | (bus.flushValid ? flush_masked : '0);
                if (pending_d == '0) state_d = IQA_NORMAL;
            end
            default: begin
                if (bus.flushValid) begin
                    pending_d = flush_masked;
                    if (|flush_masked) state_d = IQA_RECOVER;
                end
            end
        endcase
    end

    always_comb begin
        alloc_ok    = 1'b0;
        drain_valid = 1'b0;
        recover_c   = 1'b0;
        case (state_q)
            IQA_RECOVER: begin
                drain_valid = 1'b1;
                recover_c   = 1'b1;
            end
            default: begin
                alloc_ok = !rst && (req_cnt <= free_cnt) && !bus.flushValid;
            end
        endcase
    end

    // The j-th requesting slot takes the j-th entry from head; idle slots read 0.
    always_comb begin
        logic [CNT_W-1:0] rank;
        rank      = '0;
        alloc_ptr = '0;
        for (int j = 0; j < int'(DISPATCH_WIDTH); j++) begin
            if (bus.allocReq[j]) begin
                for (int s = 0; s < int'(DISPATCH_WIDTH); s++) begin
                    if (rank == CNT_W'(s)) alloc_ptr[j] = head_entry[s];
                end
                rank = rank + CNT_W'(1);
            end
        end
    end

    assign pop_cnt    = alloc_ok ? req_cnt : '0;
    assign push_valid = {drain_valid, bus.releaseValid};
    assign push_data  = {drain_idx, bus.releasePtr};

    iq_free_list_fifo #(
        .ENTRY_NUM (ENTRY_NUM),
        .POP_N     (DISPATCH_WIDTH),
        .PUSH_N    (PUSH_N)
    ) u_free_list (
        .clk          (clk),
        .rst          (rst),
        .pop_cnt_i    (pop_cnt),
        .push_valid_i (push_valid),
        .push_data_i  (push_data),
        .peek_c_o     (head_entry),
        .count_o      (free_cnt)
    );

    assign bus.allocOK    = alloc_ok;
    assign bus.allocPtr   = alloc_ptr;
    assign bus.recovering = recover_c;
    assign bus.freeCount  = free_cnt;

endmodule

// File: tb/tb_iq_entry_allocator.sv
// Bench for iq_entry_allocator: directed scenarios then random traffic, checked against
// a queue-based model of the free list and a pending-flush set.
module tb_iq_entry_allocator;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    iq_entry_allocator_if #(.ENTRY_NUM(16), .DISPATCH_WIDTH(2), .ISSUE_WIDTH(2)) bus ();

    iq_entry_allocator #(.ENTRY_NUM(16), .DISPATCH_WIDTH(2), .ISSUE_WIDTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: FIFO order of free entries, allocated set, pending flush set.
    int          free_q[$];
    logic [15:0] alloc_m;
    logic [15:0] pend_m;
    bit          rec_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
            else begin
                fails++;
                $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            end
    endtask

    task automatic model_reset();
        free_q.delete();
        for (int i = 0; i < 16; i++) free_q.push_back(i);
        alloc_m = '0;
        pend_m  = '0;
        rec_m   = 1'b0;
    endtask

    task automatic drive_idle();
        bus.allocReq     = '0;
        bus.releaseValid = '0;
        bus.releasePtr   = '0;
        bus.flushValid   = 1'b0;
        bus.flushVector  = '0;
    endtask

    // Reset held across one edge; checked while rst is still high.
    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_allocOK", bus.allocOK, 0);
        chk("rst_freeCount", bus.freeCount, 16);
        chk("rst_recovering", bus.recovering, 0);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One cycle: drive, check combinational grant and registered state, then advance model.
    task automatic step(input logic [1:0] req, input logic [1:0] rv, input logic [3:0] rp0,
                        input logic [3:0] rp1, input logic fv, input logic [15:0] fvec);
        int          k;
        int          idx;
        bit          ok;
        int          e;
        logic [15:0] relmask;
        logic [15:0] masked;
        bus.allocReq      = req;
        bus.releaseValid  = rv;
        bus.releasePtr[0] = rp0;
        bus.releasePtr[1] = rp1;
        bus.flushValid    = fv;
        bus.flushVector   = fvec;
        #1;
        k  = $countones(req);
        ok = !rec_m && (k <= free_q.size()) && !fv;
        chk("allocOK", bus.allocOK, ok);
        chk("freeCount", bus.freeCount, free_q.size());
        chk("recovering", bus.recovering, rec_m);
        idx = 0;
        if (req[0]) begin
            if (ok) chk("allocPtr0", bus.allocPtr[0], free_q[idx]);
            idx++;
        end else begin
            chk("allocPtr0_idle", bus.allocPtr[0], 0);
        end
        if (req[1]) begin
            if (ok) chk("allocPtr1", bus.allocPtr[1], free_q[idx]);
        end else begin
            chk("allocPtr1_idle", bus.allocPtr[1], 0);
        end
        @(posedge clk);
        if (ok) begin
            for (int j = 0; j < k; j++) begin
                e = free_q.pop_front();
                alloc_m[e] = 1'b1;
            end
        end
        relmask = '0;
        if (rv[0]) begin free_q.push_back(rp0); alloc_m[rp0] = 1'b0; relmask[rp0] = 1'b1; end
        if (rv[1]) begin free_q.push_back(rp1); alloc_m[rp1] = 1'b0; relmask[rp1] = 1'b1; end
        if (rec_m) begin
            for (int b = 15; b >= 0; b--) if (pend_m[b]) e = b;
            free_q.push_back(e);
            pend_m[e] = 1'b0;
        end
        masked  = fv ? (fvec & ~relmask) : 16'h0;
        pend_m  = pend_m | masked;
        alloc_m = alloc_m & ~masked;
        rec_m   = (pend_m != 0);
        @(negedge clk);
    endtask

    task automatic idle_step();
        step(2'b00, 2'b00, 4'd0, 4'd0, 1'b0, 16'h0);
    endtask

    // Random legal traffic: releases and flushes only touch currently allocated entries.
    task automatic rand_step();
        int          al[$];
        int          pick;
        logic [1:0]  rv;
        logic [3:0]  rp [2];
        logic        fv;
        logic [15:0] fvec;
        for (int i = 0; i < 16; i++) if (alloc_m[i]) al.push_back(i);
        rv    = '0;
        rp[0] = '0;
        rp[1] = '0;
        for (int p = 0; p < 2; p++) begin
            if (al.size() > 0 && $urandom_range(0, 1) == 1) begin
                pick  = $urandom_range(0, al.size() - 1);
                rp[p] = 4'(al[pick]);
                rv[p] = 1'b1;
                al.delete(pick);
            end
        end
        fv   = 1'b0;
        fvec = '0;
        if ($urandom_range(0, 11) == 0) begin
            fv = 1'b1;
            for (int i = 0; i < 16; i++) if (alloc_m[i] && $urandom_range(0, 1) == 1) fvec[i] = 1'b1;
        end
        step(2'($urandom_range(0, 3)), rv, rp[0], rp[1], fv, fvec);
    endtask

    initial begin
        drive_idle();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        do_reset();

        // Basic two-wide allocation from reset, then fill the list completely.
        step(2'b11, 2'b00, 4'd0, 4'd0, 1'b0, 16'h0);
        step(2'b11, 2'b00, 4'd0, 4'd0, 1'b0, 16'h0);
        chk("after_two_allocs", bus.freeCount, 12);
        repeat (6) step(2'b11, 2'b00, 4'd0, 4'd0, 1'b0, 16'h0);
        step(2'b01, 2'b00, 4'd0, 4'd0, 1'b0, 16'h0);
        step(2'b00, 2'b01, 4'd5, 4'd0, 1'b0, 16'h0);
        step(2'b01, 2'b00, 4'd0, 4'd0, 1'b0, 16'h0);
        step(2'b00, 2'b11, 4'd9, 4'd12, 1'b0, 16'h0);
        step(2'b10, 2'b00, 4'd0, 4'd0, 1'b0, 16'h0);
        step(2'b01, 2'b00, 4'd0, 4'd0, 1'b0, 16'h0);

        // Flush 4..7 with 4 issuing in the same cycle.
        do_reset();
        repeat (4) step(2'b11, 2'b00, 4'd0, 4'd0, 1'b0, 16'h0);
        step(2'b11, 2'b01, 4'd4, 4'd0, 1'b1, 16'h00F0);
        repeat (4) idle_step();
        chk("flush_freeCount", bus.freeCount, 12);
        chk("flush_done", bus.recovering, 0);

        // Second flush merges into pending during recovery.
        do_reset();
        repeat (4) step(2'b11, 2'b00, 4'd0, 4'd0, 1'b0, 16'h0);
        step(2'b01, 2'b00, 4'd0, 4'd0, 1'b0, 16'h0);
        step(2'b00, 2'b01, 4'd4, 4'd0, 1'b1, 16'h00F0);
        step(2'b11, 2'b00, 4'd0, 4'd0, 1'b1, 16'h0100);
        repeat (5) step(2'b11, 2'b00, 4'd0, 4'd0, 1'b0, 16'h0);

        // Random traffic with wrap-around.
        for (int c = 0; c < 200; c++) rand_step();

        // Reach a quiet NORMAL state within a bounded number of cycles.
        for (int c = 0; c < 40 && rec_m; c++) idle_step();
        chk("quiesce_bound", bus.recovering, 0);
        step(2'b11, 2'b00, 4'd0, 4'd0, 1'b0, 16'h0);
        step(2'b11, 2'b00, 4'd0, 4'd0, 1'b0, 16'h0);
        step(2'b00, 2'b00, 4'd0, 4'd0, 1'b1, alloc_m);
        idle_step();

        // Reset while recovering discards pending work.
        do_reset();
        step(2'b11, 2'b00, 4'd0, 4'd0, 1'b0, 16'h0);
        step(2'b11, 2'b00, 4'd0, 4'd0, 1'b0, 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
